// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath. Each instruction moves
// through fetch, decode, execute, memory and writeback. The states drive the
// datapath enables and mux selects. The shared instruction/data memory is
// waited on through mem_ready. Retired instructions are counted modulo 2^RET_W.
module mips_multicycle_ctrl #(
  parameter int RET_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [RET_W-1:0] retired,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t           r_state;
  state_t           w_next;
  logic [RET_W-1:0] r_retired;
  logic             w_op_legal;

  assign state   = r_state;
  assign retired = r_retired;

  // Opcode legality check, used by DECODE to flag unsupported instructions.
  always_comb begin
    unique case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: w_op_legal = 1'b1;
      default:                                       w_op_legal = 1'b0;
    endcase
  end

  // State register and retired-instruction counter.
  // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (instr_done) r_retired <= r_retired + {{(RET_W-1){1'b0}}, 1'b1};
    end
  end

  // Next-state logic. Unused encodings return to FETCH.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next = S_EXEC;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDI_EX;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      w_next = S_MEMRD;
        else if (opcode == OP_SW) w_next = S_MEMWR;
        else                      w_next = S_FETCH;
      end
      S_MEMRD:   w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:    w_next = S_RWB;
      S_ADDI_EX: w_next = S_ADDI_WB;
      default:   w_next = S_FETCH;
    endcase
  end

  // Moore output decode, with mem_ready qualifiers in FETCH and MEMWR.
  // Reset forces all outputs low.
  always_comb begin
    // NOTE: every output gets a default here first, so no latch is inferred for states that leave it unassigned.
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    instr_done    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = ~w_op_legal;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      illegal_op    = 1'b0;
      instr_done    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl with RET_W=4, so the counter wraps quickly.
module tb_mips_multicycle_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, instr_done;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] retired;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;
  int ir_cnt   = 0;
  int rw_cnt   = 0;

  mips_multicycle_ctrl #(.RET_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .instr_done(instr_done),
    .retired(retired), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of every control output, MSB first in port order.
  logic [17:0] outs;
  assign outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                 pc_source, illegal_op, instr_done};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Check the current state and the read/write exclusivity, tally enables, then advance one cycle.
  task automatic cyc(input logic [3:0] exp_st, input string tag);
    check(tag, {28'd0, state}, {28'd0, exp_st});
    check({tag, "_rw_excl"}, {31'd0, mem_read & mem_write}, 32'd0);
    check({tag, "_done_ill_excl"}, {31'd0, instr_done & illegal_op}, 32'd0);
    if (ir_write)  ir_cnt++;
    if (reg_write) rw_cnt++;
    tick();
  endtask

  initial begin
    rst = 1'b1; opcode = 6'b000000; mem_ready = 1'b1;
    #1;
    // Reset held for two cycles
    tick(); settle();
    check("rst1_outs", {14'd0, outs}, 32'd0);
    check("rst1_state", {28'd0, state}, 32'd0);
    check("rst1_retired", {28'd0, retired}, 32'd0);
    tick(); settle();
    check("rst2_outs", {14'd0, outs}, 32'd0);
    rst = 1'b0;

    // R-type with mem_ready tied high: 0,1,6,7,0
    settle();
    check("r_fetch_outs", {14'd0, outs}, {14'd0, 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0});
    cyc(4'd0, "r_s0");
    settle(); check("r_dec_asb", {30'd0, alu_src_b}, 32'd3);
    cyc(4'd1, "r_s1");
    settle(); check("r_exec_aluop", {30'd0, alu_op}, 32'd2);
    check("r_exec_regwrite", {31'd0, reg_write}, 32'd0);
    cyc(4'd6, "r_s6");
    settle();
    check("r_rwb_regwrite", {31'd0, reg_write}, 32'd1);
    check("r_rwb_regdst", {31'd0, reg_dst}, 32'd1);
    check("r_rwb_done", {31'd0, instr_done}, 32'd1);
    cyc(4'd7, "r_s7");
    settle();
    check("r_retired", {28'd0, retired}, 32'd1);

    // lw with two wait cycles in FETCH and two in MEMRD
    opcode = 6'b100011; mem_ready = 1'b0; ir_cnt = 0;
    settle(); check("lw_f0_irw", {31'd0, ir_write}, 32'd0);
    check("lw_f0_memread", {31'd0, mem_read}, 32'd1);
    cyc(4'd0, "lw_f0");
    settle(); cyc(4'd0, "lw_f1");
    mem_ready = 1'b1;
    settle(); check("lw_f2_irw", {31'd0, ir_write}, 32'd1);
    cyc(4'd0, "lw_f2");
    settle(); cyc(4'd1, "lw_dec");
    settle(); check("lw_madr_asb", {30'd0, alu_src_b}, 32'd2);
    cyc(4'd2, "lw_madr");
    mem_ready = 1'b0;
    settle(); check("lw_rd_iord", {31'd0, i_or_d}, 32'd1);
    cyc(4'd3, "lw_rd0");
    settle(); cyc(4'd3, "lw_rd1");
    mem_ready = 1'b1;
    settle(); cyc(4'd3, "lw_rd2");
    settle(); check("lw_wb_m2r", {31'd0, mem_to_reg}, 32'd1);
    check("lw_wb_done", {31'd0, instr_done}, 32'd1);
    check("lw_wb_regdst", {31'd0, reg_dst}, 32'd0);
    cyc(4'd4, "lw_wb");
    settle();
    check("lw_irw_count", ir_cnt, 32'd1);
    check("lw_retired", {28'd0, retired}, 32'd2);

    // sw with mem_ready high: 0,1,2,5,0
    opcode = 6'b101011; rw_cnt = 0;
    settle(); cyc(4'd0, "sw_f");
    settle(); check("sw_dec_memwrite", {31'd0, mem_write}, 32'd0);
    cyc(4'd1, "sw_dec");
    settle(); check("sw_madr_memwrite", {31'd0, mem_write}, 32'd0);
    cyc(4'd2, "sw_madr");
    settle();
    check("sw_wr_outs", {14'd0, outs}, {14'd0, 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_1});
    cyc(4'd5, "sw_wr");
    settle();
    check("sw_regwrite_count", rw_cnt, 32'd0);
    check("sw_retired", {28'd0, retired}, 32'd3);

    // beq then j back to back
    opcode = 6'b000100;
    settle(); cyc(4'd0, "beq_f");
    settle(); cyc(4'd1, "beq_dec");
    settle();
    check("beq_pwc", {31'd0, pc_write_cond}, 32'd1);
    check("beq_pcsrc", {30'd0, pc_source}, 32'd1);
    check("beq_aluop", {30'd0, alu_op}, 32'd1);
    cyc(4'd8, "beq_br");
    opcode = 6'b000010;
    settle(); cyc(4'd0, "j_f");
    settle(); cyc(4'd1, "j_dec");
    settle();
    check("j_pcw", {31'd0, pc_write}, 32'd1);
    check("j_pcsrc", {30'd0, pc_source}, 32'd2);
    cyc(4'd9, "j_jmp");
    settle();
    check("bj_retired", {28'd0, retired}, 32'd5);

    // Illegal opcode: one-cycle pulse in DECODE, no retire
    opcode = 6'b111111;
    settle(); check("ill_f_pulse", {31'd0, illegal_op}, 32'd0);
    cyc(4'd0, "ill_f");
    settle();
    check("ill_dec_pulse", {31'd0, illegal_op}, 32'd1);
    check("ill_dec_done", {31'd0, instr_done}, 32'd0);
    cyc(4'd1, "ill_dec");
    settle();
    check("ill_after_pulse", {31'd0, illegal_op}, 32'd0);
    check("ill_state", {28'd0, state}, 32'd0);
    check("ill_retired", {28'd0, retired}, 32'd5);

    // addi: 0,1,10,11,0
    opcode = 6'b001000;
    cyc(4'd0, "addi_f");
    settle(); cyc(4'd1, "addi_dec");
    settle(); check("addi_ex_asb", {30'd0, alu_src_b}, 32'd2);
    cyc(4'd10, "addi_ex");
    settle();
    check("addi_wb_outs", {14'd0, outs}, {14'd0, 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_0_1});
    cyc(4'd11, "addi_wb");
    settle();
    check("addi_retired", {28'd0, retired}, 32'd6);

    // Reset while stalled in MEMRD abandons the load
    opcode = 6'b100011; mem_ready = 1'b1;
    cyc(4'd0, "rlw_f");
    settle(); cyc(4'd1, "rlw_dec");
    settle(); cyc(4'd2, "rlw_madr");
    mem_ready = 1'b0;
    settle(); check("rlw_rd_state", {28'd0, state}, 32'd3);
    rst = 1'b1;
    settle();
    check("rlw_rst_outs", {14'd0, outs}, 32'd0);
    tick();
    rst = 1'b0;
    settle();
    check("rlw_state", {28'd0, state}, 32'd0);
    check("rlw_retired", {28'd0, retired}, 32'd0);

    // Counter wrap: 15 jumps, then one more wraps 15 -> 0
    opcode = 6'b000010; mem_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick(); tick(); tick();
    end
    settle();
    check("wrap_state", {28'd0, state}, 32'd0);
    check("wrap_pre", {28'd0, retired}, 32'd15);
    cyc(4'd0, "wrap_f");
    settle(); cyc(4'd1, "wrap_dec");
    settle(); cyc(4'd9, "wrap_jmp");
    settle();
    check("wrap_post", {28'd0, retired}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multi-cycle MIPS datapath. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath enables and mux selects in each state. It waits on a shared instruction/data memory through a single ready handshake and counts retired instructions. It sits beside the IR, register file, ALU and PC registers; the opcode comes from the IR output.

Parameters:
RET_W, 32, width of the retired-instruction counter (wraps modulo 2^RET_W)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
opcode  input  6  IR[31:26], stable from DECODE onward
mem_ready  input  1  memory completes the current read/write this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero (beq)
i_or_d  output  1  0=PC addresses memory, 1=ALUOut addresses memory
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  IR load
mem_to_reg  output  1  1=MDR to register file write data
reg_dst  output  1  1=rd, 0=rt
reg_write  output  1  register file write
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  output  2  00=add, 01=sub, 10=funct-decoded
pc_source  output  2  00=ALU, 01=ALUOut, 10=jump target
illegal_op  output  1  one-cycle pulse: unsupported opcode
instr_done  output  1  one-cycle pulse: instruction retires
retired  output  RET_W  count of instr_done pulses
state  output  4  current state encoding (debug)

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11. Unused encodings go to FETCH on the next edge, with all outputs 0 meanwhile.
- Reset: a clock edge with rst=1 sets state=FETCH and retired=0. While rst=1, every output except state is forced to 0. Reset mid-instruction abandons the instruction with no retire.
- Outputs are decoded from state (Moore), except for the mem_ready qualifiers below. Any output not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Holds in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EX
  - any other opcode -> FETCH, with illegal_op=1 in this DECODE cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEMRD if opcode=100011, MEMWR if opcode=101011.
- MEMRD: mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next: FETCH.
- MEMWR: mem_write=1, i_or_d=1. Holds until mem_ready. instr_done=mem_ready, and on mem_ready it goes to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next: RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Next: FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next: FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next: FETCH.
- Counter and latency:
  - retired increments on every clock edge where instr_done=1 and rst=0, wrapping at 2^RET_W-1 -> 0.
  - Latency with mem_ready tied high: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4.
- Invariants: mem_read and mem_write are never both 1. instr_done and illegal_op are never both 1.

Test Plan:
- R-type, mem_ready=1: rst high 2 cycles, then opcode=000000 -> state sequence 0,1,6,7,0. reg_write=1 and reg_dst=1 only in state 7. retired=1 after 4 cycles.
- lw with 3-cycle memory wait: mem_ready low for 2 cycles in FETCH and 2 in MEMRD. Required: ir_write pulses exactly once; state sequence 0,0,0,1,2,3,3,3,4,0; mem_to_reg=1 in state 4; retired +1.
- sw, mem_ready=1: states 0,1,2,5,0. mem_write=1 and i_or_d=1 in state 5 only. reg_write never 1.
- beq then j back-to-back: beq gives 0,1,8 with pc_write_cond=1 and pc_source=01. j gives 0,1,9 with pc_write=1 and pc_source=10. retired +2.
- Illegal opcode 111111: illegal_op=1 for exactly one cycle (state 1). Next state is 0, instr_done stays 0, retired unchanged.
- Reset during MEMRD with mem_ready=0: assert rst 1 cycle -> all outputs 0 in that cycle, state=0 afterward, retired=0. Also preload retired=2^RET_W-1 (RET_W=4, 15 instrs) and retire one more -> retired wraps to 0.
